// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: NOP encoding, default reset PC, sequential PC increment.
package pipeline_pkg;

   localparam int unsigned DEF_PC_WIDTH    = 32;
   localparam int unsigned DEF_INSTR_WIDTH = 32;
   localparam int unsigned DEF_CNT_WIDTH   = 16;

   // All-zero word is the bubble instruction injected on a flush
   localparam logic [DEF_INSTR_WIDTH-1:0] NOP_INSTR        = '0;
   localparam logic [DEF_PC_WIDTH-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned                PC_INCR          = 4;

endpackage : pipeline_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold on stall, flush to a NOP bubble, otherwise load.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
   parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [INSTR_WIDTH-1:0] load_instr,
   input  logic [PC_WIDTH-1:0]    load_pc_plus4,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    pc_plus4,
   output logic                   valid
);

   // Priority: reset > stall (hold) > flush (bubble) > load
   always_ff @(posedge clk) begin
      if (reset) begin
         instr    <= INSTR_WIDTH'(NOP_INSTR);
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else if (stall) begin
         instr    <= instr;
         pc_plus4 <= pc_plus4;
         valid    <= valid;
      end else if (flush) begin
         instr    <= INSTR_WIDTH'(NOP_INSTR);
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else begin
         instr    <= load_instr;
         pc_plus4 <= load_pc_plus4;
         valid    <= 1'b1;
      end
   end

endmodule : if_id_reg

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage control: PC register, branch/jump redirect, IF/ID register, optional perf counters.
// Optional feature: define FETCH_PERF_CNT_EN to build the stall/flush performance counters;
// otherwise stall_cycles and flush_count are constant zero.
module fetch_stage_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned          PC_WIDTH    = DEF_PC_WIDTH,
   parameter int unsigned          INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC),
   parameter int unsigned          CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pc_stall,
   input  logic                   IF_ID_stall,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   input  logic                   jump,
   input  logic [PC_WIDTH-1:0]    jump_target,
   input  logic [INSTR_WIDTH-1:0] imem_instr,
   output logic [PC_WIDTH-1:0]    imem_addr,
   output logic [PC_WIDTH-1:0]    IF_ID_pc_plus4,
   output logic [INSTR_WIDTH-1:0] IF_ID_instr,
   output logic                   IF_ID_valid,
   output logic [CNT_WIDTH-1:0]   stall_cycles,
   output logic [CNT_WIDTH-1:0]   flush_count
);

   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_plus4_c;
   logic [PC_WIDTH-1:0] target_c;
   logic                redirect_c;

   // Sequential address, redirect qualification and target select (jump wins)
   always_comb begin
      pc_plus4_c = pc_q + PC_WIDTH'(PC_INCR);
      redirect_c = (branch_taken | jump) & ~pc_stall;
      target_c   = jump ? jump_target : branch_target;
   end

   // PC register: reset > stall hold > redirect > sequential
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else if (pc_stall) begin
         pc_q <= pc_q;
      end else if (redirect_c) begin
         pc_q <= target_c;
      end else begin
         pc_q <= pc_plus4_c;
      end
   end

   assign imem_addr = pc_q;

   if_id_reg #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_if_id_reg (
      .clk           (clk),
      .reset         (reset),
      .stall         (IF_ID_stall),
      .flush         (redirect_c),
      .load_instr    (imem_instr),
      .load_pc_plus4 (pc_plus4_c),
      .instr         (IF_ID_instr),
      .pc_plus4      (IF_ID_pc_plus4),
      .valid         (IF_ID_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] flush_cnt_q;

   // Saturating counters for stalled cycles and taken redirects
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         end
         if (redirect_c && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule : fetch_stage_ctrl

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed vector table, perf-counter sequence,
// and randomized traffic against a behavioural fetch model.
module tb_fetch_stage_ctrl;

   localparam int unsigned PW = 32;
   localparam int unsigned IW = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          pc_stall;
   logic          IF_ID_stall;
   logic          branch_taken;
   logic [PW-1:0] branch_target;
   logic          jump;
   logic [PW-1:0] jump_target;
   logic [IW-1:0] imem_instr;
   logic [PW-1:0] imem_addr;
   logic [PW-1:0] IF_ID_pc_plus4;
   logic [IW-1:0] IF_ID_instr;
   logic          IF_ID_valid;
   logic [CW-1:0] stall_cycles;
   logic [CW-1:0] flush_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_stage_ctrl #(
      .PC_WIDTH    (PW),
      .INSTR_WIDTH (IW),
      .RESET_PC    (32'h0),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_stall       (pc_stall),
      .IF_ID_stall    (IF_ID_stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .imem_instr     (imem_instr),
      .imem_addr      (imem_addr),
      .IF_ID_pc_plus4 (IF_ID_pc_plus4),
      .IF_ID_instr    (IF_ID_instr),
      .IF_ID_valid    (IF_ID_valid),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   // Instruction memory contents: distinctive word derived from the address
   function automatic logic [IW-1:0] imem_of(input logic [PW-1:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign imem_instr = imem_of(imem_addr);

   // Behavioural model of the fetch stage
   logic [PW-1:0] m_pc;
   logic [PW-1:0] m_pp4;
   logic [IW-1:0] m_instr;
   logic          m_valid;
   int unsigned   m_stalls;
   int unsigned   m_flushes;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the same edge, then compare
   task automatic apply(input logic r, input logic ps, input logic is,
                        input logic bt, input logic [PW-1:0] btg,
                        input logic j, input logic [PW-1:0] jtg);
      logic          taken;
      logic [PW-1:0] dest;
      logic [PW-1:0] seq;
      reset         = r;
      pc_stall      = ps;
      IF_ID_stall   = is;
      branch_taken  = bt;
      branch_target = btg;
      jump          = j;
      jump_target   = jtg;
      taken = (bt || j) && !ps;
      dest  = j ? jtg : btg;
      seq   = m_pc + 32'd4;
      if (r) begin
         m_pc = '0; m_pp4 = '0; m_instr = '0; m_valid = 1'b0;
         m_stalls = 0; m_flushes = 0;
      end else begin
         if (!is) begin
            if (taken) begin
               m_pp4 = '0; m_instr = '0; m_valid = 1'b0;
            end else begin
               m_pp4 = seq; m_instr = imem_of(m_pc); m_valid = 1'b1;
            end
         end
         if (!ps) m_pc = taken ? dest : seq;
         if (ps && m_stalls < CNT_MAX) m_stalls++;
         if (taken && m_flushes < CNT_MAX) m_flushes++;
      end
      @(posedge clk);
      #1;
      check("imem_addr", 64'(imem_addr), 64'(m_pc));
      check("pc_plus4", 64'(IF_ID_pc_plus4), 64'(m_pp4));
      check("instr", 64'(IF_ID_instr), 64'(m_instr));
      check("valid", 64'(IF_ID_valid), 64'(m_valid));
`ifdef FETCH_PERF_CNT_EN
      check("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
      check("flush_count", 64'(flush_count), 64'(m_flushes));
`else
      check("stall_cycles_tied", 64'(stall_cycles), 64'd0);
      check("flush_count_tied", 64'(flush_count), 64'd0);
`endif
   endtask

   typedef struct {
      logic          r, ps, is, bt, j;
      logic [PW-1:0] btg, jtg;
      logic [PW-1:0] e_addr, e_pp4;
      logic [IW-1:0] e_instr;
      logic          e_valid;
   } vec_t;

   vec_t vecs[18];

   initial begin
      reset = 1'b1; pc_stall = 1'b0; IF_ID_stall = 1'b0; branch_taken = 1'b0;
      branch_target = '0; jump = 1'b0; jump_target = '0;
      m_pc = '0; m_pp4 = '0; m_instr = '0; m_valid = 1'b0; m_stalls = 0; m_flushes = 0;

      //           r  ps is bt j   btg           jtg           addr          pp4           instr          v
      vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,         0};
      vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        32'h4,        32'hC0DE0000,  1};
      vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        32'h8,        32'hC0DE0004,  1};
      vecs[3]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h8,        32'h8,        32'hC0DE0004,  1};
      vecs[4]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h8,        32'h8,        32'hC0DE0004,  1};
      vecs[5]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hC,        32'hC,        32'hC0DE0008,  1};
      vecs[6]  = '{0, 0, 0, 1, 0, 32'h40,       32'h0,        32'h40,       32'h0,        32'h0,         0};
      vecs[7]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h44,       32'h44,       32'hC0DE0040,  1};
      vecs[8]  = '{0, 1, 1, 1, 0, 32'h100,      32'h0,        32'h44,       32'h44,       32'hC0DE0040,  1};
      vecs[9]  = '{0, 0, 0, 1, 0, 32'h100,      32'h0,        32'h100,      32'h0,        32'h0,         0};
      vecs[10] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h104,      32'h104,      32'hC0DE0100,  1};
      vecs[11] = '{0, 0, 0, 1, 1, 32'h40,       32'h80,       32'h80,       32'h0,        32'h0,         0};
      vecs[12] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h84,       32'h84,       32'hC0DE0080,  1};
      vecs[13] = '{0, 1, 0, 1, 0, 32'h300,      32'h0,        32'h84,       32'h88,       32'hC0DE0084,  1};
      vecs[14] = '{0, 0, 1, 0, 1, 32'h0,        32'h200,      32'h200,      32'h88,       32'hC0DE0084,  1};
      vecs[15] = '{1, 1, 1, 1, 1, 32'h40,       32'h80,       32'h0,        32'h0,        32'h0,         0};
      vecs[16] = '{0, 0, 0, 0, 1, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,         0};
      vecs[17] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'hC0DEFFFC,  1};

      @(posedge clk); #1;

      // Directed vectors: checked against both the model and the literal table
      for (int i = 0; i < 18; i++) begin
         apply(vecs[i].r, vecs[i].ps, vecs[i].is, vecs[i].bt, vecs[i].btg, vecs[i].j, vecs[i].jtg);
         check($sformatf("vec%0d_addr", i), 64'(imem_addr), 64'(vecs[i].e_addr));
         check($sformatf("vec%0d_pp4", i), 64'(IF_ID_pc_plus4), 64'(vecs[i].e_pp4));
         check($sformatf("vec%0d_instr", i), 64'(IF_ID_instr), 64'(vecs[i].e_instr));
         check($sformatf("vec%0d_valid", i), 64'(IF_ID_valid), 64'(vecs[i].e_valid));
      end

      // Redirect latency: target fetched next cycle, valid in ID the cycle after
      apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
      check("lat_addr", 64'(imem_addr), 64'h500);
      check("lat_bubble", 64'(IF_ID_valid), 64'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("lat_target_valid", 64'(IF_ID_valid), 64'd1);
      check("lat_target_instr", 64'(IF_ID_instr), 64'hC0DE0500);

      // Counter sequence: reset, 3 stalls, 2 redirects, then reset clears
      apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
`ifdef FETCH_PERF_CNT_EN
      check("perf_stalls_3", 64'(stall_cycles), 64'd3);
      check("perf_flushes_2", 64'(flush_count), 64'd2);
`endif
      apply(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      check("perf_stalls_reset", 64'(stall_cycles), 64'd0);
      check("perf_flushes_reset", 64'(flush_count), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic r, ps, is, bt, j;
         r  = ($urandom_range(0, 59) == 0);
         ps = ($urandom_range(0, 3) == 0);
         is = ($urandom_range(0, 3) == 0) ? 1'b1 : (ps & ($urandom_range(0, 1) == 1));
         bt = ($urandom_range(0, 4) == 0);
         j  = ($urandom_range(0, 7) == 0);
         apply(r, ps, is, bt, {$urandom_range(0, 16'hFFFF), 2'b00}, j, {$urandom_range(0, 16'hFFFF), 2'b00});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_stage_ctrl
